mem_responder: RTL
==================

# mem_responder

Word-organised memory that is the responder end of the core's three bus channels: instruction read (ir), data read (dr) and data write (dw). It accepts addresses through valid/ready handshakes, returns read data after a programmable latency, and returns a write response for each store. It sits outside the core and serves as program/data memory for simulation and FPGA builds.

## Interface
- MEM_WORDS, 1024: memory depth in 32-bit words; the byte address space is 0 .. 4*MEM_WORDS-1.
- READ_LATENCY, 1: clock edges from address acceptance to data_valid assertion; legal range 1..15; applies to both read ports.
- clk  input  1  the block's single clock.
- rst  input  1  reset; synchronous and active-high.
- ir_addr_valid  input  1  instruction address valid.
- ir_addr  input  32  instruction byte address.
- ir_addr_ready  output  1  instruction address accepted when high.
- ir_data_valid  output  1  instruction data valid.
- ir_data  output  32  instruction word.
- ir_data_ready  input  1  core accepts ir_data.
- dr_addr_valid, dr_addr, dr_addr_ready, dr_data_valid, dr_data, dr_data_ready: same directions, widths and meanings as the ir_* ports, for the data-read channel.
- dw_data_addr_valid  input  1  write address, data and strobe valid.
- dw_addr  input  32  write byte address.
- dw_data  input  32  write data, already lane-aligned.
- dw_strobe  input  4  byte-lane enables; bit i enables dw_data[8i+7:8i].
- dw_data_addr_ready  output  1  write accepted when high.
- dw_resp_valid  output  1  write response valid.
- dw_resp  output  1  1 = OK, 0 = FAIL.
- dw_resp_ready  input  1  core accepts the response.

## Operation
- Word index = addr[31:2]. addr[1:0] is ignored.
- An index is out of range when it is >= MEM_WORDS.
- Each read port runs its own FSM with states IDLE, WAIT and RESP.
  - IDLE: addr_ready=1. On addr_valid, latch the word and go to WAIT when READ_LATENCY>1, or straight to RESP when READ_LATENCY=1.
  - WAIT: addr_ready=0. A down-counter, loaded with READ_LATENCY-1, decrements each cycle; enter RESP when it reaches 1.
  - RESP: data_valid=1 and data held stable. On data_ready go to IDLE.
- Read data comes from the array contents at the acceptance edge. An out-of-range read returns 32'h0.
- Write FSM, state IDLE:
  - dw_data_addr_ready=1.
  - On dw_data_addr_valid with an in-range index, write each strobed byte lane at that edge and set dw_resp=1.
  - With an out-of-range index, write nothing and set dw_resp=0.
  - Either way, go to RESP.
- Write FSM, state RESP: dw_data_addr_ready=0 and dw_resp_valid=1. On dw_resp_ready go to IDLE.
- dw_strobe=0 with an in-range index writes nothing and still responds OK.
- Simultaneous events:
  - A write and a read accepted on the same edge to the same word: the read returns the post-write word (write-first bypass, merged per byte lane).
  - ir and dr reading the same word both return it.
- The memory array is not reset. Contents after power-up are X in simulation.

## Timing
- Reset values: ir_addr_ready=1, dr_addr_ready=1, dw_data_addr_ready=1; ir_data_valid=0, dr_data_valid=0, dw_resp_valid=0; ir_data=0, dr_data=0, dw_resp=0.
- While rst=1, no handshake is accepted and no memory write occurs.
- rst asserted mid-operation returns every FSM to IDLE at that edge and drops pending responses. Memory writes already committed are kept.
- All outputs are registered.
- Read latency: address accepted at edge E, then data_valid high from edge E+READ_LATENCY until and including the edge where data_ready=1.
  - Zero-wait acceptance (data_ready already high) gives a per-port throughput of one read per READ_LATENCY+1 cycles.
- Write: accepted at edge E, then dw_resp_valid high from edge E+1. dw_data_addr_ready returns to 1 on the edge after the response handshake.
- Back-pressure (ready low) holds data and response values stable.
- Ports are independent; no port stalls another.

## Test plan
- Write 32'hDEADBEEF to 0x10 with strobe 4'hF, then read 0x10 on dr with READ_LATENCY=1 -> dw_resp=1 one cycle after acceptance; dr_data_valid one cycle after address acceptance with dr_data=32'hDEADBEEF.
- Preload word 0x10 with 32'h11223344; write dw_data=32'h00AA0000 with strobe 4'b0100 -> reading 0x12 (word 0x10) returns 32'h11AA3344.
- READ_LATENCY=3, dr_data_ready held low for 5 cycles -> dr_data_valid rises 3 edges after acceptance; dr_data stays stable; dr_addr_ready=0 until the cycle after the handshake.
- Write to byte address 4*MEM_WORDS -> dw_resp=0, no array change. A read of the same address returns 32'h0.
- Write 32'hCAFEF00D to 0x20 and read dr at 0x20 accepted on the same edge -> dr_data=32'hCAFEF00D. An ir read of 0x20 issued in parallel returns the same value.
- rst pulsed while dr is in WAIT and dw is in RESP -> next cycle: all valids 0, all readies 1; a new read completes normally.

Source files
------------

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : mem_responder
// Purpose : Word-organised memory serving instruction-read, data-read and
//           data-write bus channels with programmable read latency.
// Revision: 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int MEM_WORDS    = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ir_addr_valid,
    input  logic [31:0] ir_addr,
    output logic        ir_addr_ready,
    output logic        ir_data_valid,
    output logic [31:0] ir_data,
    input  logic        ir_data_ready,
    input  logic        dr_addr_valid,
    input  logic [31:0] dr_addr,
    output logic        dr_addr_ready,
    output logic        dr_data_valid,
    output logic [31:0] dr_data,
    input  logic        dr_data_ready,
    input  logic        dw_data_addr_valid,
    input  logic [31:0] dw_addr,
    input  logic [31:0] dw_data,
    input  logic [3:0]  dw_strobe,
    output logic        dw_data_addr_ready,
    output logic        dw_resp_valid,
    output logic        dw_resp,
    input  logic        dw_resp_ready
);
    localparam int         AW          = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0] c_lat_m1    = 4'(READ_LATENCY - 1);
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_wait   = 2'd1;
    localparam logic [1:0] c_st_resp   = 2'd2;
    localparam logic       c_wst_idle  = 1'b0;
    localparam logic       c_wst_resp  = 1'b1;

    logic [31:0] mem_q [MEM_WORDS];

    // ---------------- write channel ----------------
    logic          dw_state_q, dw_state_d;
    logic          dw_data_addr_ready_q, dw_data_addr_ready_d;
    logic          dw_resp_valid_q, dw_resp_valid_d;
    logic          dw_resp_q, dw_resp_d;
    logic          w_dw_fire;
    logic          w_dw_idx_ok;
    logic [AW-1:0] w_dw_idx;
    logic          w_unused;

    assign w_unused    = ^{ir_addr[1:0], dr_addr[1:0], dw_addr[1:0]};
    assign w_dw_idx_ok = (dw_addr[31:2] < 30'(MEM_WORDS));
    assign w_dw_idx    = dw_addr[AW+1:2];
    assign w_dw_fire   = (dw_state_q == c_wst_idle) && dw_data_addr_valid && !rst;

    always_ff @(posedge clk) begin
        if (w_dw_fire && w_dw_idx_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (dw_strobe[b]) mem_q[w_dw_idx][8*b +: 8] <= dw_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dw_state_q           <= c_wst_idle;
            dw_data_addr_ready_q <= 1'b1;
            dw_resp_valid_q      <= 1'b0;
            dw_resp_q            <= 1'b0;
        end else begin
            dw_state_q           <= dw_state_d;
            dw_data_addr_ready_q <= dw_data_addr_ready_d;
            dw_resp_valid_q      <= dw_resp_valid_d;
            dw_resp_q            <= dw_resp_d;
        end
    end

    always_comb begin
        dw_state_d = dw_state_q;
        dw_resp_d  = dw_resp_q;
        case (dw_state_q)
            c_wst_idle: begin
                if (dw_data_addr_valid) begin
                    dw_state_d = c_wst_resp;
                    dw_resp_d  = w_dw_idx_ok;
                end
            end
            default: begin
                if (dw_resp_ready) dw_state_d = c_wst_idle;
            end
        endcase
    end

    always_comb begin
        dw_data_addr_ready_d = (dw_state_d == c_wst_idle);
        dw_resp_valid_d      = (dw_state_d == c_wst_resp);
    end

    assign dw_data_addr_ready = dw_data_addr_ready_q;
    assign dw_resp_valid      = dw_resp_valid_q;
    assign dw_resp            = dw_resp_q;

    // ---------------- read channels (0 = ir, 1 = dr) ----------------
    logic [1:0]  w_rd_addr_valid, w_rd_data_ready, w_rd_addr_ready, w_rd_data_valid;
    logic [31:0] w_rd_addr [2];
    logic [31:0] w_rd_data [2];

    assign w_rd_addr_valid = {dr_addr_valid, ir_addr_valid};
    assign w_rd_data_ready = {dr_data_ready, ir_data_ready};
    assign w_rd_addr[0]    = ir_addr;
    assign w_rd_addr[1]    = dr_addr;

    for (genvar p = 0; p < 2; p++) begin : g_rd_port
        logic [1:0]    state_q, state_d;
        logic [3:0]    cnt_q, cnt_d;
        logic [31:0]   data_q, data_d;
        logic          addr_ready_q, addr_ready_d;
        logic          data_valid_q, data_valid_d;
        logic          w_idx_ok;
        logic [AW-1:0] w_idx;
        logic [31:0]   w_word;

        assign w_idx_ok = (w_rd_addr[p][31:2] < 30'(MEM_WORDS));
        assign w_idx    = w_rd_addr[p][AW+1:2];

        // A store landing on the same word this edge is merged lane by lane.
        always_comb begin
            w_word = 32'h0;
            if (w_idx_ok) begin
                w_word = mem_q[w_idx];
                if (w_dw_fire && w_dw_idx_ok && (w_dw_idx == w_idx)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (dw_strobe[b]) w_word[8*b +: 8] = dw_data[8*b +: 8];
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q      <= c_st_idle;
                cnt_q        <= 4'd0;
                data_q       <= 32'h0;
                addr_ready_q <= 1'b1;
                data_valid_q <= 1'b0;
            end else begin
                state_q      <= state_d;
                cnt_q        <= cnt_d;
                data_q       <= data_d;
                addr_ready_q <= addr_ready_d;
                data_valid_q <= data_valid_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            data_d  = data_q;
            case (state_q)
                c_st_idle: begin
                    if (w_rd_addr_valid[p]) begin
                        data_d  = w_word;
                        cnt_d   = c_lat_m1;
                        state_d = (READ_LATENCY > 1) ? c_st_wait : c_st_resp;
                    end
                end
                c_st_wait: begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = c_st_resp;
                end
                c_st_resp: begin
                    if (w_rd_data_ready[p]) state_d = c_st_idle;
                end
                default: state_d = c_st_idle;
            endcase
        end

        always_comb begin
            addr_ready_d = (state_d == c_st_idle);
            data_valid_d = (state_d == c_st_resp);
        end

        assign w_rd_addr_ready[p] = addr_ready_q;
        assign w_rd_data_valid[p] = data_valid_q;
        assign w_rd_data[p]       = data_q;
    end

    assign ir_addr_ready = w_rd_addr_ready[0];
    assign ir_data_valid = w_rd_data_valid[0];
    assign ir_data       = w_rd_data[0];
    assign dr_addr_ready = w_rd_addr_ready[1];
    assign dr_data_valid = w_rd_data_valid[1];
    assign dr_data       = w_rd_data[1];
endmodule
`default_nettype wire
